// File: rtl/xgmii_rx_frame_stats.sv
// rtl/xgmii_rx_frame_stats.sv - XGMII receive frame delimiter with per-frame length/error records,
// wrapping good/bad frame counters and a stretched activity LED.
module xgmii_rx_frame_stats #(
  parameter int MIN_LEN     = 64,
  parameter int MAX_LEN     = 1518,
  parameter int LED_STRETCH = 24
) (
  input  logic        xgmii_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic [7:0]  xphy_status,
  output logic        stat_valid,
  output logic [15:0] stat_len,
  output logic [3:0]  stat_err,
  output logic [31:0] frame_cnt,
  output logic [31:0] err_cnt,
  output logic        led_activity
);
  typedef enum logic {IDLE, FRAME} state_t;

  localparam logic [16:0] R_MAX = '1;
  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  state_t      state_q, state_d;
  logic [16:0] r_q, r_d;
  logic        bad_q, bad_d;
  logic [7:0]  is_start, is_term, is_bad;
  logic [3:0]  term_any, term_s0, term_s4;
  logic        lock;
  logic        close, close_abort, close_bad;
  logic [16:0] close_r, len_full;
  logic [15:0] close_len;
  logic [3:0]  close_err;
  logic [LED_STRETCH-1:0] led_q;
  logic        unused_status;

  function automatic logic [16:0] sat_add(input logic [16:0] a, input logic [16:0] b);
    logic [17:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[17] ? R_MAX : s[16:0];
  endfunction

  // {found, lane} of the lowest set bit of v.
  function automatic logic [3:0] lowest(input logic [7:0] v);
    logic [3:0] res;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) res = {1'b1, 3'(i)};
    return res;
  endfunction

  function automatic logic [7:0] below(input logic [2:0] k);
    return (8'd1 << k) - 8'd1;
  endfunction

  assign lock          = xphy_status[0];
  assign unused_status = ^xphy_status[7:1];

  always_comb begin
    is_start = '0;
    is_term  = '0;
    is_bad   = '0;
    for (int i = 0; i < 8; i++) begin
      is_term[i]  = xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] == 8'hFD);
      is_start[i] = (i == 0 || i == 4) && xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] == 8'hFB);
      is_bad[i]   = xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] != 8'h07) && !is_term[i] && !is_start[i];
    end
  end

  assign term_any = lowest(is_term);
  assign term_s0  = lowest(is_term & 8'hFE);
  assign term_s4  = lowest(is_term & 8'hE0);

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    bad_d       = bad_q;
    close       = 1'b0;
    close_abort = 1'b0;
    close_r     = r_q;
    close_bad   = bad_q;
    case (state_q)
      IDLE: begin
        if (lock && is_start[0]) begin
          if (term_s0[3]) begin
            close     = 1'b1;
            close_r   = 17'(term_s0[2:0]) - 17'd1;
            close_bad = |(is_bad & 8'hFE & below(term_s0[2:0]));
          end else begin
            state_d = FRAME;
            r_d     = 17'd7;
            bad_d   = |(is_bad & 8'hFE);
          end
        end else if (lock && is_start[4]) begin
          if (term_s4[3]) begin
            close     = 1'b1;
            close_r   = 17'(term_s4[2:0]) - 17'd5;
            close_bad = |(is_bad & 8'hE0 & below(term_s4[2:0]));
          end else begin
            state_d = FRAME;
            r_d     = 17'd3;
            bad_d   = |(is_bad & 8'hE0);
          end
        end
      end
      FRAME: begin
        if (!lock) begin
          close       = 1'b1;
          close_abort = 1'b1;
          state_d     = IDLE;
        end else if (is_start[0]) begin
          close       = 1'b1;
          close_abort = 1'b1;
          r_d         = 17'd7;
          bad_d       = |(is_bad & 8'hFE);
        end else if (term_any[3] && (!is_start[4] || term_any[2:0] < 3'd4)) begin
          close     = 1'b1;
          close_r   = sat_add(r_q, 17'(term_any[2:0]));
          close_bad = bad_q | (|(is_bad & below(term_any[2:0])));
          // A START in lane 4 behind the terminator opens the next frame in the same word.
          if (is_start[4]) begin
            r_d   = 17'd3;
            bad_d = |(is_bad & 8'hE0);
          end else begin
            state_d = IDLE;
          end
        end else if (is_start[4]) begin
          close       = 1'b1;
          close_abort = 1'b1;
          close_r     = sat_add(r_q, 17'd4);
          close_bad   = bad_q | (|is_bad[3:0]);
          r_d         = 17'd3;
          bad_d       = |(is_bad & 8'hE0);
        end else begin
          r_d   = sat_add(r_q, 17'd8);
          bad_d = bad_q | (|is_bad);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    len_full  = (close_r >= 17'd7) ? close_r - 17'd7 : 17'd0;
    close_len = len_full[16] ? 16'hFFFF : len_full[15:0];
    close_err = {close_len > MAX_L, close_len < MIN_L, close_abort, close_bad};
  end

  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      bad_q   <= bad_d;
    end
  end

  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stat_valid <= 1'b0;
      stat_len   <= '0;
      stat_err   <= '0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
      led_q      <= '0;
    end else begin
      stat_valid <= close;
      if (close) begin
        stat_len <= close_len;
        stat_err <= close_err;
        if (close_err == 4'd0) frame_cnt <= frame_cnt + 32'd1;
        else                   err_cnt   <= err_cnt + 32'd1;
        led_q <= '1;
      end else if (led_q != '0) begin
        led_q <= led_q - LED_STRETCH'(1);
      end
    end
  end

  assign led_activity = |led_q;

endmodule

// File: tb/tb_xgmii_rx_frame_stats.sv
// tb/tb_xgmii_rx_frame_stats.sv - directed bench for xgmii_rx_frame_stats with a byte-stream model.
module tb_xgmii_rx_frame_stats;
  logic        xgmii_clk = 1'b0;
  logic        sys_rst_n;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic [7:0]  xphy_status;
  logic        stat_valid;
  logic [15:0] stat_len;
  logic [3:0]  stat_err;
  logic [31:0] frame_cnt;
  logic [31:0] err_cnt;
  logic        led_activity;

  xgmii_rx_frame_stats dut (
    .xgmii_clk    (xgmii_clk),
    .sys_rst_n    (sys_rst_n),
    .xgmii_rxd    (xgmii_rxd),
    .xgmii_rxc    (xgmii_rxc),
    .xphy_status  (xphy_status),
    .stat_valid   (stat_valid),
    .stat_len     (stat_len),
    .stat_err     (stat_err),
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt),
    .led_activity (led_activity)
  );

  always #5 xgmii_clk = ~xgmii_clk;

  typedef struct {
    logic [7:0]  d;
    logic        c;
    logic        nolock;
    logic        mark;
    logic [15:0] elen;
    logic [3:0]  eerr;
  } lane_t;

  typedef struct {
    int          due;
    logic [15:0] len;
    logic [3:0]  err;
  } exp_t;

  lane_t       lq[$];
  exp_t        eq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          pos_total = 0;
  int          fstart = 0;
  int          n_pulses = 0;
  logic [31:0] m_frames = '0;
  logic [31:0] m_errs = '0;
  logic        m_seen = 1'b0;
  logic [15:0] last_len = '0;
  logic [3:0]  last_err = '0;

  always @(posedge xgmii_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sat16(input int v);
    if (v < 0) return 16'd0;
    if (v > 65535) return 16'hFFFF;
    return 16'(v);
  endfunction

  function automatic logic [3:0] exp_err(input int len, input logic ab, input logic bd);
    return {len > 1518, len < 64, ab, bd};
  endfunction

  task automatic push_lane(input logic [7:0] d, input logic c, input logic nl,
                           input logic mk, input logic [15:0] elen, input logic [3:0] eerr);
    lane_t l;
    l.d = d; l.c = c; l.nolock = nl; l.mark = mk; l.elen = elen; l.eerr = eerr;
    lq.push_back(l);
    pos_total++;
  endtask

  task automatic push_idle();
    push_lane(8'h07, 1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
  endtask

  // Frame length is the distance from START to the closing lane, minus START and 7 preamble/SFD.
  function automatic int cur_len();
    int len;
    len = pos_total - fstart - 8;
    return (len < 0) ? 0 : len;
  endfunction

  task automatic open_frame(input int lane, input logic abort_prev);
    int len;
    while (pos_total % 8 != lane) push_idle();
    len = cur_len();
    push_lane(8'hFB, 1'b1, 1'b0, abort_prev, sat16(len), exp_err(len, 1'b1, 1'b0));
    fstart = pos_total - 1;
    repeat (6) push_lane(8'h55, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0);
    push_lane(8'hD5, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0);
  endtask

  task automatic payload(input int n, input int bad_idx);
    for (int j = 0; j < n; j++) begin
      if (j == bad_idx) push_lane(8'hFE, 1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
      else              push_lane(8'(j), 1'b0, 1'b0, 1'b0, 16'd0, 4'd0);
    end
  endtask

  task automatic close_term(input logic bd);
    int len;
    len = cur_len();
    push_lane(8'hFD, 1'b1, 1'b0, 1'b1, sat16(len), exp_err(len, 1'b0, bd));
  endtask

  task automatic lock_drop();
    int len;
    len = cur_len();
    push_lane(8'h07, 1'b1, 1'b1, 1'b1, sat16(len), exp_err(len, 1'b1, 1'b0));
    repeat (7) push_lane(8'h07, 1'b1, 1'b1, 1'b0, 16'd0, 4'd0);
  endtask

  task automatic flush();
    logic [63:0] d;
    logic [7:0]  c;
    logic        lk;
    lane_t       l;
    while (pos_total % 8 != 0) push_idle();
    while (lq.size() > 0) begin
      @(negedge xgmii_clk);
      lk = 1'b1;
      for (int i = 0; i < 8; i++) begin
        l = lq.pop_front();
        d[8*i +: 8] = l.d;
        c[i] = l.c;
        if (l.nolock) lk = 1'b0;
        if (l.mark) eq.push_back('{due: cyc + 1, len: l.elen, err: l.eerr});
      end
      xgmii_rxd   = d;
      xgmii_rxc   = c;
      xphy_status = {7'd0, lk};
    end
  endtask

  task automatic idle(input int n);
    repeat (8 * n) push_idle();
    flush();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stat_valid"}, stat_valid, 0);
    chk({tag, "_stat_len"}, stat_len, 0);
    chk({tag, "_stat_err"}, stat_err, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_led"}, led_activity, 0);
  endtask

  // Compare process: every cycle out of reset, outputs against the model.
  initial begin
    exp_t e;
    forever begin
      @(negedge xgmii_clk);
      #1;
      if (sys_rst_n === 1'b1) begin
        if (stat_valid) begin
          n_pulses++;
          last_len = stat_len;
          last_err = stat_err;
          if (eq.size() == 0) begin
            chk("unexpected_stat_valid", stat_valid, 0);
          end else begin
            e = eq.pop_front();
            chk("stat_cycle", cyc, e.due);
            chk("stat_len", stat_len, e.len);
            chk("stat_err", stat_err, e.err);
            if (e.err == 4'd0) m_frames = m_frames + 32'd1;
            else               m_errs   = m_errs + 32'd1;
            m_seen = 1'b1;
          end
        end else if (eq.size() > 0 && eq[0].due < cyc) begin
          chk("missing_stat", stat_valid, 1);
          void'(eq.pop_front());
        end
        chk("frame_cnt", frame_cnt, m_frames);
        chk("err_cnt", err_cnt, m_errs);
        chk("led_activity", led_activity, m_seen);
      end
    end
  end

  initial begin
    int p0;
    sys_rst_n   = 1'b0;
    xgmii_rxd   = 64'h0707070707070707;
    xgmii_rxc   = 8'hFF;
    xphy_status = 8'h01;
    repeat (3) @(negedge xgmii_clk);
    chk_all_zero("reset");
    sys_rst_n = 1'b1;
    idle(2);

    // 64-byte frame, START lane 0, TERM lane 0.
    open_frame(0, 1'b0); payload(64, -1); close_term(1'b0); flush(); idle(3);
    chk("t1_len", last_len, 16'd64);
    chk("t1_err", last_err, 4'd0);
    chk("t1_frame_cnt", frame_cnt, 32'd1);

    // 60-byte runt, START lane 4.
    open_frame(4, 1'b0); payload(60, -1); close_term(1'b0); flush(); idle(3);
    chk("t2_len", last_len, 16'd60);
    chk("t2_err", last_err, 4'b0100);
    chk("t2_err_cnt", err_cnt, 32'd1);

    // Giants, including length saturation.
    open_frame(0, 1'b0); payload(1600, -1); close_term(1'b0); flush(); idle(3);
    chk("t3_len", last_len, 16'd1600);
    chk("t3_err", last_err, 4'b1000);
    open_frame(0, 1'b0); payload(70000, -1); close_term(1'b0); flush(); idle(3);
    chk("t3_sat_len", last_len, 16'hFFFF);

    // TERM lane 2 and START lane 4 in the same word.
    p0 = n_pulses;
    open_frame(0, 1'b0); payload(66, -1); close_term(1'b0);
    open_frame(4, 1'b0); payload(100, -1); close_term(1'b0); flush(); idle(3);
    chk("t4_records", n_pulses - p0, 2);
    chk("t4_len", last_len, 16'd100);

    // Block lock lost mid-frame, then a control error character in lane 3.
    open_frame(0, 1'b0); payload(80, -1); lock_drop(); flush(); idle(3);
    chk("t5_lock_err", last_err, 4'b0010);
    chk("t5_lock_len", last_len, 16'd80);
    open_frame(0, 1'b0); payload(100, 11); close_term(1'b1); flush(); idle(3);
    chk("t5_bad_err", last_err, 4'b0001);

    // START and TERM in one word; then a START aborting an open frame.
    while (pos_total % 8 != 0) push_idle();
    push_lane(8'hFB, 1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
    payload(4, -1);
    push_lane(8'hFD, 1'b1, 1'b0, 1'b1, 16'd0, exp_err(0, 1'b0, 1'b0));
    flush(); idle(2);
    chk("same_word_err", last_err, 4'b0100);
    open_frame(0, 1'b0); payload(72, -1); open_frame(0, 1'b1); payload(64, -1); close_term(1'b0);
    flush(); idle(3);
    chk("abort_then_good_err", last_err, 4'd0);

    // Frame counter wrap.
    @(negedge xgmii_clk);
    force dut.frame_cnt = 32'hFFFFFFFF;
    m_frames = 32'hFFFFFFFF;
    @(negedge xgmii_clk);
    release dut.frame_cnt;
    idle(2);
    open_frame(0, 1'b0); payload(64, -1); close_term(1'b0); flush(); idle(3);
    chk("wrap_frame_cnt", frame_cnt, 32'd0);

    // Reset in the middle of a frame: nothing reported for it afterwards.
    open_frame(0, 1'b0); payload(40, -1); flush();
    @(negedge xgmii_clk);
    sys_rst_n = 1'b0;
    m_frames = '0; m_errs = '0; m_seen = 1'b0;
    eq.delete();
    #1;
    chk_all_zero("midrst");
    @(negedge xgmii_clk);
    @(negedge xgmii_clk);
    sys_rst_n = 1'b1;
    payload(30, -1);
    push_lane(8'hFD, 1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
    flush(); idle(6);
    chk("midrst_no_stat_cnt", err_cnt + frame_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
